// File: rtl/cpu_flags_pkg.sv
// cpu_flags_pkg
//   Shared definitions for the CPU status/flags register and its
//   condition-code evaluator.
//   - FLAG_Z/N/C/V : bit positions of the architectural flags in the flag word
//   - cond_code_e  : 4-bit condition selector used by conditional branches
package cpu_flags_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_code_e;

endpackage

// File: rtl/flags_cond_eval.sv
// flags_cond_eval
//   Purely combinational condition-code evaluator for conditional branches.
//   Ports:
//     flags     in  [3:0]  architectural flags {V, C, N, Z}
//     cond_code in  [3:0]  condition selector (cond_code_e encoding)
//     cond_true out        1 when the selected condition holds
module flags_cond_eval
  import cpu_flags_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond_code,
  output logic       cond_true
);

  logic z, n, c, v;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b0;
    case (cond_code_e'(cond_code))
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = n ~^ v;
      COND_LT: cond_true = n ^ v;
      COND_GT: cond_true = ~z & (n ~^ v);
      COND_LE: cond_true = z | (n ^ v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_flags_stack.sv
// status_flags_stack
//   CPU status/flags register with per-bit ALU update masks, a software
//   write port, a LIFO save/restore stack for interrupt entry/return with
//   sticky overflow/underflow errors, and a condition-code evaluator.
//   Ports:
//     clk, reset          clock; asynchronous active-high reset
//     alu_flags           new flag values from the ALU
//     alu_upd_mask        per-bit update enable for alu_flags
//     sw_wr_en/sw_wr_data software write of the whole flag word
//     push / pop          save / restore flags (interrupt entry / return)
//     err_clr             clear both sticky error bits
//     cond_code           condition selector
//     flags               registered flag word
//     cond_true           condition result, combinational from flags
//     depth               number of valid stack entries
//     stack_full/empty    depth == STACK_DEPTH / depth == 0
//     err_overflow        sticky: push attempted while full
//     err_underflow       sticky: pop attempted while empty
module status_flags_stack
  import cpu_flags_pkg::*;
#(
  parameter int NUM_FLAGS   = 4,
  parameter int STACK_DEPTH = 4,
  parameter int DCNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_FLAGS-1:0] alu_flags,
  input  logic [NUM_FLAGS-1:0] alu_upd_mask,
  input  logic                 sw_wr_en,
  input  logic [NUM_FLAGS-1:0] sw_wr_data,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 err_clr,
  input  logic [3:0]           cond_code,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 cond_true,
  output logic [DCNT_W-1:0]    depth,
  output logic                 stack_full,
  output logic                 stack_empty,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam logic [DCNT_W-1:0] DEPTH_MAX = DCNT_W'(STACK_DEPTH);

  logic [NUM_FLAGS-1:0]   flags_reg, flags_next;
  logic [NUM_FLAGS-1:0]   alu_merge;
  logic [NUM_FLAGS-1:0]   pop_data;
  logic [DCNT_W-1:0]      depth_reg, depth_next;
  logic                   err_ovf_reg, err_ovf_next;
  logic                   err_unf_reg, err_unf_next;
  logic [NUM_FLAGS-1:0]   stack_reg [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] top_hit;
  logic                   full, empty;
  logic                   push_only, pop_only;
  logic                   push_ok, pop_ok;

  assign full  = (depth_reg == DEPTH_MAX);
  assign empty = (depth_reg == '0);

  // push and pop together cancel out: neither touches the stack nor errors.
  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign push_ok   = push_only & ~full;
  assign pop_ok    = pop_only & ~empty;

  // Per-bit masked ALU merge.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_alu_merge
      assign alu_merge[gi] = alu_upd_mask[gi] ? alu_flags[gi] : flags_reg[gi];
    end
  endgenerate

  // Top-of-stack select: entry gi is the top when depth == gi+1.
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_top_hit
      assign top_hit[gi] = (depth_reg == DCNT_W'(gi + 1));
    end
  endgenerate

  always_comb begin
    pop_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (top_hit[i]) begin
        pop_data = stack_reg[i];
      end
    end
  end

  // Restore beats software write, which beats the ALU.
  always_comb begin
    flags_next = alu_merge;
    if (sw_wr_en) begin
      flags_next = sw_wr_data;
    end
    if (pop_ok) begin
      flags_next = pop_data;
    end
  end

  always_comb begin
    depth_next = depth_reg;
    if (push_ok) begin
      depth_next = depth_reg + DCNT_W'(1);
    end else if (pop_ok) begin
      depth_next = depth_reg - DCNT_W'(1);
    end
  end

  // A fresh error in the same cycle as err_clr keeps the bit set.
  assign err_ovf_next = (push_only & full) | (err_ovf_reg & ~err_clr);
  assign err_unf_next = (pop_only & empty) | (err_unf_reg & ~err_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg   <= '0;
      depth_reg   <= '0;
      err_ovf_reg <= 1'b0;
      err_unf_reg <= 1'b0;
    end else begin
      flags_reg   <= flags_next;
      depth_reg   <= depth_next;
      err_ovf_reg <= err_ovf_next;
      err_unf_reg <= err_unf_next;
    end
  end

  // Stack contents need no reset; depth alone marks which entries are valid.
  // The saved word is the pre-update flag value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push_ok && (depth_reg == DCNT_W'(i))) begin
        stack_reg[i] <= flags_reg;
      end
    end
  end

  flags_cond_eval u_cond_eval (
    .flags     (flags_reg[FLAG_V:FLAG_Z]),
    .cond_code (cond_code),
    .cond_true (cond_true)
  );

  assign flags         = flags_reg;
  assign depth         = depth_reg;
  assign stack_full    = full;
  assign stack_empty   = empty;
  assign err_overflow  = err_ovf_reg;
  assign err_underflow = err_unf_reg;

endmodule

// File: doc/status_flags_stack.md
Name: status_flags_stack

Overview:
- Parametrised CPU status/flags register for the 16-bit core.
- Adds per-flag update masks and a software write port (move-to-SR).
- Adds a LIFO save/restore stack for interrupt entry/return, with sticky overflow/underflow error flags.
- Adds a combinational condition-code evaluator for conditional branches.
- Sits between the ALU flag outputs and the control unit and branch logic.

Parameters:
- NUM_FLAGS, 4, flag count; must be >= 4. Bit 0 = Z, 1 = N, 2 = C, 3 = V; higher bits are general/user flags.
- STACK_DEPTH, 4, number of saved flag words (>= 1).
- DCNT_W, $clog2(STACK_DEPTH+1), width of the depth counter (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alu_flags  in  NUM_FLAGS  new flag values from the ALU.
- alu_upd_mask  in  NUM_FLAGS  per-bit update enable for alu_flags.
- sw_wr_en  in  1  software write of the whole flag word.
- sw_wr_data  in  NUM_FLAGS  software write value.
- push  in  1  save current flags to the stack (interrupt entry).
- pop  in  1  restore flags from the stack (interrupt return).
- err_clr  in  1  clear sticky error bits.
- cond_code  in  4  condition selector.
- flags  out  NUM_FLAGS  registered flag word.
- cond_true  out  1  condition result (combinational from flags, cond_code).
- depth  out  DCNT_W  number of valid stack entries.
- stack_full  out  1  depth == STACK_DEPTH.
- stack_empty  out  1  depth == 0.
- err_overflow  out  1  sticky: push attempted while full.
- err_underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, any time including mid-operation):
  - flags = 0, depth = 0, err_overflow = 0, err_underflow = 0.
  - Stack contents don't-care.
  - Outputs valid in the cycle after reset deasserts.
- Next-flags priority, all at posedge; one source per cycle:
  1. Valid pop (pop & ~push & depth > 0): flags <= stack[depth-1]. ALU and sw updates that cycle are discarded.
  2. Otherwise sw_wr_en: flags <= sw_wr_data. ALU update discarded.
  3. Otherwise: for each bit i, flags[i] <= alu_upd_mask[i] ? alu_flags[i] : flags[i].
- Valid push (push & ~pop & depth < STACK_DEPTH):
  - stack[depth] <= current registered flags (pre-update value).
  - depth <= depth + 1.
  - A same-cycle sw/ALU update still applies to flags.
- push & pop in the same cycle:
  - Stack and depth unchanged, no error.
  - flags follow the sw/ALU rules (priorities 2 and 3).
- Push while full: no write, depth unchanged, err_overflow <= 1.
- Pop while empty:
  - depth unchanged, flags not restored, err_underflow <= 1.
  - sw/ALU updates that cycle do apply.
- Error bits:
  - err_clr clears both error bits.
  - If a new error occurs in the same cycle as err_clr, the error wins (bit is set).
- Latency: all register effects are visible on outputs 1 cycle after the triggering edge. cond_true has zero latency relative to flags.
- Condition codes (Z, N, C, V = flags[0..3]):
  - 0 EQ = Z; 1 NE = ~Z
  - 2 CS = C; 3 CC = ~C
  - 4 MI = N; 5 PL = ~N
  - 6 VS = V; 7 VC = ~V
  - 8 HI = C & ~Z; 9 LS = ~C | Z
  - 10 GE = N ~^ V; 11 LT = N ^ V
  - 12 GT = ~Z & (N ~^ V); 13 LE = Z | (N ^ V)
  - 14 AL = 1; 15 NV = 0
- Stack storage is a plain register array with no wrap-around. depth saturates at 0 and STACK_DEPTH.

Decomposition:
- Shared package cpu_flags_pkg:
  - Flag index constants FLAG_Z = 0, FLAG_N = 1, FLAG_C = 2, FLAG_V = 3.
  - 4-bit cond_code enum (COND_EQ .. COND_NV).
- One sub-module: flags_cond_eval (purely combinational, inputs flags[3:0] and cond_code, output cond_true).
- Stack and flag register stay in the top module.

Test Plan:
- Reset then alu_flags = 4'b1111, alu_upd_mask = 4'b0101 -> flags = 4'b0101 next cycle; reset asserted mid-sequence -> flags = 0, depth = 0 immediately.
- flags = 4'b0011, push; next cycle alu writes 4'b1100 with mask 4'b1111, then pop -> depth goes 1 -> 0 and flags = 4'b0011 after the pop.
- 4 pushes -> stack_full = 1, depth = 4; 5th push -> err_overflow = 1, depth = 4. Then 4 pops restore saved words in LIFO order.
- Pop at depth 0 with sw_wr_en = 1, sw_wr_data = 4'b1001 -> err_underflow = 1, flags = 4'b1001. Then err_clr -> err_underflow = 0. err_clr together with a bad pop -> err_underflow stays 1.
- Same cycle: push & pop at depth 2 -> depth stays 2, no error. Same cycle: pop & sw_wr_en -> restored value wins.
- Sweep all 16 cond_code values over all 16 ZNCV combinations -> cond_true matches the table. Spot check: Z = 0, N = 1, V = 1 -> GT = 1; LT = 0.
